// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver that turns the serial pin into bytes with a valid/ack handoff.
// It also raises a one-cycle framing-error pulse and a sticky overrun flag.
module uart_rx_deframer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  input  logic       rd_ack,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [15:0] LP_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LP_HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [1:0]  r_sync;
  logic        w_rx_s;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ferr;
  logic        r_ovr;

  logic        w_cnt_half;
  logic        w_cnt_full;
  logic        w_entry;
  logic        w_shift_en;
  logic        w_good_stop;
  logic        w_bad_stop;
  logic        w_busy;

  // The line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  assign w_rx_s     = r_sync[1];
  assign w_cnt_half = (r_cnt == LP_HALF_LAST);
  assign w_cnt_full = (r_cnt == LP_BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (ena && !w_rx_s) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_cnt_half) begin
          w_state_next = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_cnt_full && (r_bit_cnt == 3'd7)) begin
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_cnt_full) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_entry     = (w_state_next != r_state);
    w_shift_en  = (r_state == S_DATA) && w_cnt_full;
    w_good_stop = (r_state == S_STOP) && w_cnt_full && w_rx_s;
    w_bad_stop  = (r_state == S_STOP) && w_cnt_full && !w_rx_s;
    w_busy      = (r_state != S_IDLE);
  end

  // Both counters restart on every state entry, so each phase times from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 16'd0;
      r_bit_cnt <= 3'd0;
    end else if (w_entry || (r_state == S_IDLE)) begin
      r_cnt     <= 16'd0;
      r_bit_cnt <= 3'd0;
    end else if (w_shift_en) begin
      r_cnt     <= 16'd0;
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end else begin
      r_cnt     <= r_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= 8'h00;
    end else if (w_shift_en) begin
      r_shift <= {w_rx_s, r_shift[7:1]};
    end
  end

  // A good stop always wins over rd_ack; overrun only when the old byte was never taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_bad_stop;
      if (w_good_stop) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        if (r_valid && !rd_ack) begin
          r_ovr <= 1'b1;
        end
      end else if (rd_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;
  assign busy       = w_busy;

endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Serial byte receiver for the project's top-level pin interface: deframes 8N1 UART traffic arriving on a dedicated input pin and presents each byte on a parallel bus with a valid/acknowledge handshake. It is the receiving end of the serial link that the project's transmit path, or the cocotb bench acting as host, drives. It also reports framing errors and overruns for the top level to map onto output pins.

## Interface

- CLKS_PER_BIT, default 16: clock cycles per serial bit. Legal range is 4 to 65535, and the value must be even. H = CLKS_PER_BIT/2.

- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous reset, active-low.
  - One clock, `clk`. Reset is asynchronous on assertion and active-low (`rst_n`).
  - All flops clear when `rst_n` goes low; release is sampled on the next `clk` edge.
- ena  input  1  design-selected enable. While low, the FSM is held in IDLE and no new frame starts.
- rx  input  1  serial line, idle-high, asynchronous to clk.
- rd_ack  input  1  single-cycle pulse that consumes the held byte.
- data_out  output  8  last correctly framed byte. Reset value 0x00.
- data_valid  output  1  high while an unconsumed byte is held. Reset value 0.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low. Reset value 0.
- overrun  output  1  sticky flag. Reset value 0. Cleared only by reset.
- busy  output  1  high whenever the FSM is not in IDLE. Reset value 0.

## Operation

- `rx` passes through a 2-flop synchronizer; the synchronizer's reset value is 1. All logic below uses `rx_s`, the synchronized signal.
- A bit counter counts 0 to 7. A 16-bit cycle counter `cnt` counts 0 to CLKS_PER_BIT-1. Both clear on every state entry.
- IDLE: when `ena`=1 and `rx_s`=0, go to START.
- START: when `cnt` = H-1, sample `rx_s`.
  - If 0, go to DATA.
  - If 1, treat it as a glitch and return to IDLE silently, with no flags.
- DATA: when `cnt` = CLKS_PER_BIT-1, shift `rx_s` into the shift register, LSB first.
  - After the 8th bit, go to STOP.
- STOP: when `cnt` = CLKS_PER_BIT-1, sample `rx_s`.
  - If 1: load `data_out` from the shift register and set `data_valid`.
  - If 0: pulse `frame_err` for one cycle. `data_out` and `data_valid` are unchanged.
  - In both cases, return to IDLE.
- Overrun: if a good stop bit arrives while `data_valid`=1 and `rd_ack`=0 that cycle:
  - Set `overrun`.
  - Overwrite `data_out` with the new byte.
  - `data_valid` stays 1.
- `rd_ack` while `data_valid`=1 clears `data_valid` on the next edge. `rd_ack` while `data_valid`=0 is ignored.
- Simultaneous `rd_ack` and good stop: the new byte loads, `data_valid` stays 1, and no overrun is flagged.
- `ena` falling mid-frame: the current frame completes normally. `ena` only gates the IDLE to START transition.
- Break condition (`rx` held low): the frame ends with `frame_err`. The FSM then sees `rx_s`=0 in IDLE and restarts; each following frame also ends with `frame_err`.
- Reset mid-frame: all state returns to its reset value immediately and the partial byte is discarded.

## Timing

- Let T be the first clk edge at which `rx`=0 is sampled by synchronizer stage 1.
  - `rx_s`=0 at edge T+2.
  - IDLE to START transition at T+3.
- Start-bit check occurs H cycles after START entry.
- Data bit k (k = 0 to 7) is sampled CLKS_PER_BIT × (k+1) cycles after DATA entry, i.e. at the middle of the bit.
- `data_valid` (or `frame_err`) is visible from edge T+3+H+9·CLKS_PER_BIT (±1 for state-entry edges). The bench must allow ±1 cycle.
- `busy` rises at T+3 and falls on the same edge that `data_valid` or `frame_err` asserts.
- Back-to-back frames with a one-bit stop are accepted: IDLE is re-entered about H cycles before the next start edge.
- Tolerance: ±4% baud mismatch must still sample every bit correctly.

## Test plan

- Reset: hold `rst_n`=0 with `rx`=1, then release. Required: all outputs 0, `busy`=0, no `frame_err` pulses for 100 cycles.
- Single byte: CLKS_PER_BIT=8, send 0xA5. Required: `data_out`=0xA5 and `data_valid`=1 within the timing window; `rd_ack` pulse then clears `data_valid`.
- Framing error: send 0x3C with the stop bit low. Required: one `frame_err` pulse; `data_valid` stays 0 and `data_out` keeps its previous value.
- Glitch rejection: drive `rx` low for 2 cycles in IDLE. Required: `busy` pulses briefly, then returns to IDLE; no `data_valid` or `frame_err`.
- Overrun: send 0x11 then 0x22 back-to-back with no `rd_ack`. Required: `data_out`=0x22, `data_valid`=1, `overrun`=1. A repeat with `rd_ack` given on the exact stop cycle of 0x22 yields `overrun`=0.
- Robustness:
  - Baud skew: send 0x55 and 0xFF at +4% and -4% baud skew; both must be received correctly.
  - Mid-frame reset: assert `rst_n` during bit 4 of a frame. Required: no output is produced; the next frame is received correctly.
